// File: rtl/rom_loader_if.sv
// rom_loader_if: control, serial-bit, shift-register and ROM-write signals of rom_loader
interface rom_loader_if #(parameter int ADDR_W = 15);
    logic              start_i;
    logic              abort_i;
    logic [ADDR_W:0]   length_i;
    logic              bit_i;
    logic              bit_valid_i;
    logic [15:0]       word_i;
    logic              shift_en_o;
    logic              shift_in_o;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [15:0]       wr_data_o;
    logic              busy_o;
    logic              done_o;
    logic              overrun_o;
    logic [15:0]       checksum_o;
    modport slave (
        input  start_i, abort_i, length_i, bit_i, bit_valid_i, word_i,
        output shift_en_o, shift_in_o, wr_en_o, wr_addr_o, wr_data_o,
               busy_o, done_o, overrun_o, checksum_o
    );
    modport master (
        output start_i, abort_i, length_i, bit_i, bit_valid_i, word_i,
        input  shift_en_o, shift_in_o, wr_en_o, wr_addr_o, wr_data_o,
               busy_o, done_o, overrun_o, checksum_o
    );
endinterface

// File: rtl/rom_loader.sv
// rom_loader: serial-to-ROM loader; optional word checksum under ROM_LOADER_CHECKSUM_EN
module rom_loader #(parameter int ADDR_W = 15) (
    input logic        clk,
    input logic        reset,
    rom_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, WRITE, DONE} state_t;
    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W:0]   r_len;
    logic [15:0]       r_wr_data;
    logic              r_overrun;
    logic              w_start;
    logic              w_last;
    logic              w_write;
    assign w_start = bus.start_i && !bus.abort_i && (r_state == IDLE || r_state == DONE);
    assign w_last  = {1'b0, r_addr} == r_len - (ADDR_W+1)'(1);
    assign w_write = r_state == WRITE && !bus.abort_i;
    assign bus.shift_en_o = r_state == SHIFT && bus.bit_valid_i;
    assign bus.shift_in_o = r_state == SHIFT && bus.bit_i;
    assign bus.wr_en_o    = w_write;
    assign bus.wr_addr_o  = w_write ? r_addr : r_wr_addr;
    assign bus.wr_data_o  = w_write ? bus.word_i : r_wr_data;
    assign bus.busy_o     = r_state == SHIFT || r_state == WRITE;
    assign bus.done_o     = r_state == DONE;
    assign bus.overrun_o  = r_overrun;
    // load sequencer: collect 16 bits, write one word, repeat until length words are stored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_overrun <= 1'b0;
        end else if (bus.abort_i) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                SHIFT: begin
                    if (bus.bit_valid_i) begin
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == 4'd15) r_state <= WRITE;
                    end
                end
                WRITE: begin
                    r_wr_addr <= r_addr;
                    r_wr_data <= bus.word_i;
                    if (bus.bit_valid_i) r_overrun <= 1'b1;
                    if (w_last) begin
                        r_state <= DONE;
                    end else begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_state <= SHIFT;
                    end
                end
                default: begin
                    if (w_start) begin
                        r_len     <= bus.length_i;
                        r_cnt     <= '0;
                        r_addr    <= '0;
                        r_overrun <= 1'b0;
                        r_state   <= bus.length_i == '0 ? DONE : SHIFT;
                    end
                end
            endcase
        end
    end
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0] r_sum;
    // running modulo-2^16 sum of every word actually written, cleared by each accepted start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_sum <= '0;
        else if (w_start) r_sum <= '0;
        else if (w_write) r_sum <= r_sum + bus.word_i;
    end
    assign bus.checksum_o = r_sum;
`else
    assign bus.checksum_o = '0;
`endif
endmodule
